mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the CPU's single-port memory bus. It services the CPU's address, write strobe and write data, and returns registered read data.
- Contains a word-addressed synchronous RAM plus a small memory-mapped I/O page: LED register, synchronized switch input, a 16-bit cycle timer with compare, and a status register.
- Sits at the top level between the CPU and the board pins.

Parameters:
- RAM_DEPTH, 1024, number of 16-bit RAM words; RAM decodes addresses 0 .. RAM_DEPTH-1.
- IO_BASE, 16'hFF00, base address of the I/O page (offsets 0x00-0x04 used).
- SW_WIDTH, 8, width of the switch input and LED output.
- PROT_LIMIT, 16'h0100, first writable RAM address; used only with the optional feature.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-low reset.
- Mem_Addr  input  16  word address from the CPU.
- Mem_Write  input  1  1 = write Data_In at Mem_Addr this cycle.
- Data_In  input  16  write data (the CPU's data output).
- Mem_Data  output  16  registered read data to the CPU.
- Switches  input  SW_WIDTH  asynchronous board switches.
- Leds  output  SW_WIDTH  LED register.
- Irq  output  1  timer-match sticky flag (status bit 0).

Behaviour:
- Reset (Reset==0 at a rising edge):
  - Mem_Data=0, Leds=0, counter=0, compare=16'hFFFF, status=0, switch synchronizer flops=0.
  - Any write presented in the same cycle is discarded.
  - RAM contents are not cleared.
- Read latency is 1 cycle. Mem_Data is loaded at the edge that samples Mem_Addr and holds until the next edge.
- Read-during-write to the same address is read-first: Mem_Data returns the old value.
- Address map:
  - 0 .. RAM_DEPTH-1: RAM, read/write.
  - IO_BASE+0: LEDs, R/W, low SW_WIDTH bits; upper bits read 0.
  - IO_BASE+1: switches, RO, zero-extended.
  - IO_BASE+2: counter, R/W.
  - IO_BASE+3: compare, R/W.
  - IO_BASE+4: status, bit0 = timer match, bit1 = protect violation; write-1-to-clear.
  - Any other address reads 16'h0000; writes to it are ignored.
- Switches pass through a 2-flop synchronizer. A switch change is visible in a read issued 2 edges after the change has been sampled.
- Counter:
  - Increments by 1 every cycle; wraps 16'hFFFF -> 0.
  - A CPU write to the counter loads Data_In and overrides that cycle's increment.
- Match:
  - When the counter value equals compare, status bit0 is set at the next edge.
  - If a match and a W1C of bit0 occur in the same cycle, set wins.
  - Irq = status bit0.
- Writes take effect at the edge. A read issued in the cycle after a write returns the new value.

Optional Feature:
- Macro: MEM_WRITE_PROTECT_EN.
- Defined:
  - RAM writes with Mem_Addr < PROT_LIMIT are suppressed and set status bit1 (sticky, W1C).
  - A violation and a W1C of bit1 in the same cycle: set wins.
- Undefined: all RAM addresses are writable and status bit1 always reads 0.

Test Plan:
- Write 0x0010=16'hBEEF, then read 0x0010 -> Mem_Data=16'hBEEF one edge after the read address is sampled. A simultaneous write 16'h1234 plus read of 0x0010 returns 16'hBEEF; the following read returns 16'h1234.
- Write IO_BASE+0 = 16'h00A5 -> Leds=8'hA5 after that edge; read-back returns 16'h00A5. Read 0x8000 -> 16'h0000.
- Switches change 8'h00 -> 8'h3C -> reads of IO_BASE+1 return 16'h0000 until 2 edges after the change, then 16'h003C.
- Write compare=16'h0005 and counter=16'h0000 -> Irq rises 6 edges after the counter write. Write status=16'h0001 -> Irq clears. Counter at 16'hFFFF wraps to 16'h0000.
- Drive Reset=0 for one edge while Mem_Write=1 to IO_BASE+0 -> Leds=0, Mem_Data=0, Irq=0, compare reads 16'hFFFF. A RAM word written before reset still reads back its value.
- MEM_WRITE_PROTECT_EN defined: write 0x0050=16'hAAAA -> RAM unchanged and status reads 16'h0002. Write 0x0200=16'hAAAA -> succeeds. With the macro undefined, both writes succeed and status bit1 stays 0.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU's single-port memory bus.
// It holds a word-addressed synchronous RAM and a small I/O page at IO_BASE:
//   +0 LEDs, +1 switches (synchronized), +2 free-running counter,
//   +3 compare, +4 status (bit0 timer match, bit1 protect violation, W1C).
// Read data is registered, with 1-cycle latency and read-first behaviour.
// Optional macro MEM_WRITE_PROTECT_EN blocks RAM writes below PROT_LIMIT and
// records each blocked write in status bit1.
module mem_responder #(
    parameter int          RAM_DEPTH  = 1024,
    parameter logic [15:0] IO_BASE    = 16'hFF00,
    parameter int          SW_WIDTH   = 8,
    parameter logic [15:0] PROT_LIMIT = 16'h0100
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [15:0]         Mem_Addr,
    input  logic                Mem_Write,
    input  logic [15:0]         Data_In,
    output logic [15:0]         Mem_Data,
    input  logic [SW_WIDTH-1:0] Switches,
    output logic [SW_WIDTH-1:0] Leds,
    output logic                Irq
);

    localparam int          ADDR_W = $clog2(RAM_DEPTH);
    localparam logic [16:0] RAM_TOP = 17'(RAM_DEPTH);
    localparam logic [15:0] A_LED  = IO_BASE;
    localparam logic [15:0] A_SW   = IO_BASE + 16'd1;
    localparam logic [15:0] A_CNT  = IO_BASE + 16'd2;
    localparam logic [15:0] A_CMP  = IO_BASE + 16'd3;
    localparam logic [15:0] A_STAT = IO_BASE + 16'd4;

`ifdef MEM_WRITE_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic [15:0]         ram [RAM_DEPTH];
    logic [ADDR_W-1:0]   ram_idx;
    logic                in_ram;
    logic                sel_led, sel_sw, sel_cnt, sel_cmp, sel_stat;
    logic                wr_ok, ram_wr_req, prot_viol, ram_we;
    logic [15:0]         rd_data;
    logic [SW_WIDTH-1:0] sw_meta, sw_sync, leds_q;
    logic [15:0]         counter, compare;
    logic [1:0]          status, status_nxt, clr;

    // Address decode and write qualification; writes during reset are dropped.
    always_comb begin
        ram_idx    = Mem_Addr[ADDR_W-1:0];
        in_ram     = {1'b0, Mem_Addr} < RAM_TOP;
        sel_led    = (Mem_Addr == A_LED);
        sel_sw     = (Mem_Addr == A_SW);
        sel_cnt    = (Mem_Addr == A_CNT);
        sel_cmp    = (Mem_Addr == A_CMP);
        sel_stat   = (Mem_Addr == A_STAT);
        wr_ok      = Mem_Write & Reset;
        ram_wr_req = wr_ok & in_ram;
        prot_viol  = PROT_EN & ram_wr_req & (Mem_Addr < PROT_LIMIT);
        ram_we     = ram_wr_req & ~prot_viol;
    end

    // Read mux over the pre-edge state, which gives read-first behaviour.
    always_comb begin
        rd_data = 16'h0000;
        if (in_ram)
            rd_data = ram[ram_idx];
        else if (sel_led)
            rd_data = 16'(leds_q);
        else if (sel_sw)
            rd_data = 16'(sw_sync);
        else if (sel_cnt)
            rd_data = counter;
        else if (sel_cmp)
            rd_data = compare;
        else if (sel_stat)
            rd_data = {14'b0, status};
    end

    // Sticky status flags: a set in the same cycle as its W1C wins.
    always_comb begin
        clr           = (wr_ok && sel_stat) ? Data_In[1:0] : 2'b00;
        status_nxt[0] = (counter == compare) | (status[0] & ~clr[0]);
        status_nxt[1] = prot_viol | (status[1] & ~clr[1]);
    end

    // RAM array has no reset so its contents survive Reset.
    always_ff @(posedge Clock) begin
        if (ram_we)
            ram[ram_idx] <= Data_In;
    end

    // Registered read data, I/O registers, switch synchronizer and timer.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Mem_Data <= 16'h0000;
            sw_meta  <= '0;
            sw_sync  <= '0;
            leds_q   <= '0;
            counter  <= 16'h0000;
            compare  <= 16'hFFFF;
            status   <= 2'b00;
        end else begin
            Mem_Data <= rd_data;
            sw_meta  <= Switches;
            sw_sync  <= sw_meta;
            if (Mem_Write && sel_led)
                leds_q <= Data_In[SW_WIDTH-1:0];
            counter <= (Mem_Write && sel_cnt) ? Data_In : counter + 16'd1;
            if (Mem_Write && sel_cmp)
                compare <= Data_In;
            status <= status_nxt;
        end
    end

    assign Leds = leds_q;
    assign Irq  = status[0];

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: the driver pushes the expected
// response of every issued cycle, the monitor pops and compares it once the
// DUT has registered that cycle.
module tb_mem_responder;

    logic        Clock;
    logic        Reset;
    logic [15:0] Mem_Addr;
    logic        Mem_Write;
    logic [15:0] Data_In;
    logic [15:0] Mem_Data;
    logic [7:0]  Switches;
    logic [7:0]  Leds;
    logic        Irq;

    mem_responder dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Mem_Addr  (Mem_Addr),
        .Mem_Write (Mem_Write),
        .Data_In   (Data_In),
        .Mem_Data  (Mem_Data),
        .Switches  (Switches),
        .Leds      (Leds),
        .Irq       (Irq)
    );

`ifdef MEM_WRITE_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc++;

    typedef struct {
        int          cyc;
        bit          chk;
        logic [15:0] data;
        logic [7:0]  leds;
        bit          irq;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state
    logic [15:0] ram_m   [1024];
    bit          known_m [1024];
    logic [7:0]  leds_m;
    logic [15:0] counter_m;
    logic [15:0] compare_m;
    bit          match_flag_m;
    bit          prot_flag_m;
    logic [7:0]  sw_delay[$];
    logic [7:0]  sw_drv;

    task automatic model_reset();
        leds_m       = 8'h00;
        counter_m    = 16'h0000;
        compare_m    = 16'hFFFF;
        match_flag_m = 1'b0;
        prot_flag_m  = 1'b0;
        sw_delay     = {8'h00, 8'h00};
    endtask

    // Applies one clock edge to the model; returns the value read at that edge.
    task automatic model_step(input logic [15:0] addr, input bit we,
                              input logic [15:0] din, input bit rst,
                              output logic [15:0] rd, output bit rd_known);
        bit hit, viol;
        rd       = 16'h0000;
        rd_known = 1'b1;
        if (rst) begin
            model_reset();
            return;
        end
        if (addr < 16'd1024) begin
            rd       = ram_m[addr[9:0]];
            rd_known = known_m[addr[9:0]];
        end else begin
            case (addr)
                16'hFF00: rd = {8'h00, leds_m};
                16'hFF01: rd = {8'h00, sw_delay[0]};
                16'hFF02: rd = counter_m;
                16'hFF03: rd = compare_m;
                16'hFF04: rd = {14'b0, prot_flag_m, match_flag_m};
                default:  rd = 16'h0000;
            endcase
        end
        hit  = (counter_m == compare_m);
        viol = PROT_EN && we && addr < 16'd1024 && addr < 16'h0100;
        if (we && addr == 16'hFF04) begin
            if (din[0]) match_flag_m = 1'b0;
            if (din[1]) prot_flag_m  = 1'b0;
        end
        if (hit)  match_flag_m = 1'b1;
        if (viol) prot_flag_m  = 1'b1;
        counter_m = counter_m + 16'd1;
        if (we) begin
            case (addr)
                16'hFF00: leds_m    = din[7:0];
                16'hFF02: counter_m = din;
                16'hFF03: compare_m = din;
                default: ;
            endcase
            if (addr < 16'd1024 && !viol) begin
                ram_m[addr[9:0]]   = din;
                known_m[addr[9:0]] = 1'b1;
            end
        end
        sw_delay.push_back(sw_drv);
        void'(sw_delay.pop_front());
    endtask

    // Issue one bus cycle and record what the DUT must show after its edge.
    task automatic bus(input logic [15:0] addr, input bit we,
                       input logic [15:0] din, input bit rst, input string name);
        exp_t        e;
        logic [15:0] rd;
        bit          known;
        @(posedge Clock);
        #1;
        Mem_Addr  = addr;
        Mem_Write = we;
        Data_In   = din;
        Reset     = ~rst;
        Switches  = sw_drv;
        model_step(addr, we, din, rst, rd, known);
        e.cyc  = cyc;
        e.chk  = known;
        e.data = rd;
        e.leds = leds_m;
        e.irq  = match_flag_m;
        e.name = name;
        sbq.push_back(e);
    endtask

    // Monitor: compare every cycle already registered by the DUT.
    always @(negedge Clock) begin
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            exp_t e;
            e = sbq.pop_front();
            if (e.chk) begin
                n_checks++;
                if (Mem_Data === e.data) n_pass++;
                else $display("FAIL %s data: got %h expected %h (cycle %0d)",
                              e.name, Mem_Data, e.data, e.cyc);
            end
            n_checks++;
            if (Leds === e.leds) n_pass++;
            else $display("FAIL %s leds: got %h expected %h (cycle %0d)",
                          e.name, Leds, e.leds, e.cyc);
            n_checks++;
            if (Irq === e.irq) n_pass++;
            else $display("FAIL %s irq: got %b expected %b (cycle %0d)",
                          e.name, Irq, e.irq, e.cyc);
        end
    end

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 9))
            0, 1:    return 16'($urandom_range(0, 15));
            2, 3:    return 16'h0200 + 16'($urandom_range(0, 15));
            4:       return 16'($urandom_range(0, 1023));
            5, 6, 7: return 16'hFF00 + 16'($urandom_range(0, 5));
            8:       return 16'h8000;
            default: return 16'h0400;
        endcase
    endfunction

    initial begin
        Reset     = 1'b0;
        Mem_Addr  = 16'h0000;
        Mem_Write = 1'b0;
        Data_In   = 16'h0000;
        sw_drv    = 8'h00;
        Switches  = 8'h00;
        for (int i = 0; i < 1024; i++) known_m[i] = 1'b0;
        model_reset();

        bus(16'h0000, 0, 16'h0000, 1, "reset");
        bus(16'hFF00, 1, 16'h00A5, 1, "reset_wr");

        // RAM write, read, read-during-write
        bus(16'h0010, 1, 16'hBEEF, 0, "ram_wr");
        bus(16'h0010, 0, 16'h0000, 0, "ram_rd");
        bus(16'h0010, 1, 16'h1234, 0, "ram_rdw");
        bus(16'h0010, 0, 16'h0000, 0, "ram_rd_new");

        // LEDs and unmapped address
        bus(16'hFF00, 1, 16'h00A5, 0, "led_wr");
        bus(16'hFF00, 0, 16'h0000, 0, "led_rd");
        bus(16'h8000, 1, 16'h5555, 0, "unmapped_wr");
        bus(16'h8000, 0, 16'h0000, 0, "unmapped_rd");

        // Switch synchronizer
        for (int i = 0; i < 3; i++) bus(16'hFF01, 0, 16'h0000, 0, "sw_old");
        sw_drv = 8'h3C;
        for (int i = 0; i < 5; i++) bus(16'hFF01, 0, 16'h0000, 0, "sw_new");

        // Timer match, W1C, wrap
        bus(16'hFF03, 1, 16'h0005, 0, "cmp_wr");
        bus(16'hFF02, 1, 16'h0000, 0, "cnt_wr");
        for (int i = 0; i < 8; i++) bus(16'hFF04, 0, 16'h0000, 0, "match_wait");
        bus(16'hFF04, 1, 16'h0001, 0, "stat_w1c");
        bus(16'hFF04, 0, 16'h0000, 0, "stat_rd");
        bus(16'hFF02, 1, 16'hFFFE, 0, "cnt_wr_hi");
        for (int i = 0; i < 3; i++) bus(16'hFF02, 0, 16'h0000, 0, "cnt_wrap");

        // Reset keeps RAM, clears I/O
        bus(16'h0020, 1, 16'h5A5A, 0, "ram_wr2");
        bus(16'hFF00, 1, 16'h00FF, 0, "led_wr2");
        bus(16'hFF00, 1, 16'h00A5, 1, "mid_reset");
        bus(16'hFF00, 0, 16'h0000, 0, "led_after_rst");
        bus(16'hFF03, 0, 16'h0000, 0, "cmp_after_rst");
        bus(16'h0020, 0, 16'h0000, 0, "ram_after_rst");

        // Write protect region
        bus(16'h0050, 1, 16'hAAAA, 0, "prot_wr_lo");
        bus(16'h0050, 0, 16'h0000, 0, "prot_rd_lo");
        bus(16'hFF04, 0, 16'h0000, 0, "prot_stat");
        bus(16'h0200, 1, 16'hAAAA, 0, "prot_wr_hi");
        bus(16'h0200, 0, 16'h0000, 0, "prot_rd_hi");
        bus(16'hFF04, 1, 16'h0003, 0, "stat_clr_all");
        bus(16'hFF04, 0, 16'h0000, 0, "stat_clr_rd");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) sw_drv = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                bus(16'hFF03, 1, 16'($urandom_range(0, 40)) + counter_m, 0, "rnd_cmp");
            end else begin
                bus(rand_addr(), ($urandom_range(0, 2) == 0), 16'($urandom),
                    ($urandom_range(0, 49) == 0), "rnd");
            end
        end

        bus(16'h0000, 0, 16'h0000, 0, "tail");
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        n_checks++;
        if (sbq.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d entries left, expected 0", sbq.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
